// File: rtl/uart_tx_data.sv
// uart_tx_data
//   Builds the host-bound telemetry frame and feeds it to the byte UART TX.
//   The frame is 12 bytes: "ST", flag, threshold, X hi/lo, Y hi/lo, an XOR
//   checksum over bytes 2..7, and then "END". The flag, threshold and
//   coordinates are captured when i_SEND is taken, so later input changes do
//   not alter a frame that is already in flight.
//
// Ports
//   i_CLK, i_RST_N     clock, asynchronous active-low reset
//   i_SEND             one-cycle frame request (ignored while busy)
//   i_COLOR_FLAG       colour/binary mode flag to report
//   i_THRESHOLD        binary threshold to report
//   i_X, i_Y           marker centroid, truncated to 16 bits in the frame
//   o_TX_DV            strobe to the UART TX: o_TX_BYTE is valid
//   o_TX_BYTE          byte for the UART TX
//   i_TX_ACTIVE        UART TX is shifting a byte
//   i_TX_DONE          UART TX finished the stop bit
//   o_BUSY             frame in progress
//   o_FRAME_DONE       one-cycle pulse after the last byte completes
//   o_State            FSM state, for debug
module uart_tx_data #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned COORD_W    = 16
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_SEND,
  input  logic               i_COLOR_FLAG,
  input  logic [7:0]         i_THRESHOLD,
  input  logic [COORD_W-1:0] i_X,
  input  logic [COORD_W-1:0] i_Y,
  output logic               o_TX_DV,
  output logic [7:0]         o_TX_BYTE,
  input  logic               i_TX_ACTIVE,
  input  logic               i_TX_DONE,
  output logic               o_BUSY,
  output logic               o_FRAME_DONE,
  output logic [2:0]         o_State
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [3:0] LAST_IDX = 4'd11;

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]    state_q,   state_d;
  logic [3:0]    idx_q,     idx_d;
  logic [GW-1:0] gap_q,     gap_d;
  logic          flag_q,    flag_d;
  logic [7:0]    thr_q,     thr_d;
  logic [15:0]   x_q,       x_d;
  logic [15:0]   y_q,       y_d;
  logic [7:0]    csum_q,    csum_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          busy_q,    busy_d;
  logic          fdone_q,   fdone_d;

  logic [3:0]    byte_sel;
  logic [7:0]    frame_byte;

  // The byte register is loaded on entry to ISSUE so that o_TX_DV can be
  // raised combinationally in ISSUE as soon as the transmitter is idle.
  // Leaving WAIT the index has not yet advanced, hence the +1 there.
  always_comb begin
    byte_sel = (state_q == S_WAIT) ? idx_q + 4'd1 : idx_q;
    case (byte_sel)
      4'd0:    frame_byte = 8'h53;
      4'd1:    frame_byte = 8'h54;
      4'd2:    frame_byte = {7'b0, flag_q};
      4'd3:    frame_byte = thr_q;
      4'd4:    frame_byte = x_q[15:8];
      4'd5:    frame_byte = x_q[7:0];
      4'd6:    frame_byte = y_q[15:8];
      4'd7:    frame_byte = y_q[7:0];
      4'd8:    frame_byte = csum_q;
      4'd9:    frame_byte = 8'h45;
      4'd10:   frame_byte = 8'h4E;
      4'd11:   frame_byte = 8'h44;
      default: frame_byte = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    flag_d    = flag_q;
    thr_d     = thr_q;
    x_d       = x_q;
    y_d       = y_q;
    csum_d    = csum_q;
    tx_byte_d = tx_byte_q;
    busy_d    = busy_q;
    fdone_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The FSM is already back in IDLE while o_FRAME_DONE is high; a
        // request in that cycle still belongs to the finishing frame.
        if (i_SEND && !fdone_q) begin
          flag_d  = i_COLOR_FLAG;
          thr_d   = i_THRESHOLD;
          x_d     = 16'(i_X);
          y_d     = 16'(i_Y);
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        csum_d    = {7'b0, flag_q} ^ thr_q ^ x_q[15:8] ^ x_q[7:0]
                    ^ y_q[15:8] ^ y_q[7:0];
        tx_byte_d = frame_byte;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (!i_TX_ACTIVE) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_TX_DONE) begin
          if (idx_q == LAST_IDX) begin
            fdone_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
            if (GAP_CYCLES > 0) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              tx_byte_d = frame_byte;
              state_d   = S_ISSUE;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          tx_byte_d = frame_byte;
          state_d   = S_ISSUE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      flag_q    <= 1'b0;
      thr_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      csum_q    <= '0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      flag_q    <= flag_d;
      thr_q     <= thr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      csum_q    <= csum_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
    end
  end

  assign o_TX_DV      = (state_q == S_ISSUE) && !i_TX_ACTIVE;
  assign o_TX_BYTE    = tx_byte_q;
  assign o_BUSY       = busy_q;
  assign o_FRAME_DONE = fdone_q;
  assign o_State      = state_q;

endmodule

// File: tb/tb_uart_tx_data.sv
// tb_uart_tx_data
//   Two instances share the stimulus: one with no inter-byte gap and one
//   with a 4-clock gap. Each has its own byte-UART model (10-clock byte
//   time, done pulse after active drops). Bytes are captured on the
//   falling edge and compared against hand-written frame tables.
module tb_uart_tx_data;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        send;
  logic        flag;
  logic [7:0]  thr;
  logic [15:0] x;
  logic [15:0] y;
  logic        hold_active;

  logic        dv     [2];
  logic [7:0]  tbyte  [2];
  logic        busy   [2];
  logic        fdone  [2];
  logic [2:0]  st     [2];
  logic        act_m  [2];
  logic        done_m [2];
  logic        tx_act [2];
  int unsigned cnt_m  [2];

  assign tx_act[0] = act_m[0] | hold_active;
  assign tx_act[1] = act_m[1] | hold_active;

  uart_tx_data #(.GAP_CYCLES(0), .COORD_W(16)) u_dut_g0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_SEND(send), .i_COLOR_FLAG(flag),
    .i_THRESHOLD(thr), .i_X(x), .i_Y(y), .o_TX_DV(dv[0]),
    .o_TX_BYTE(tbyte[0]), .i_TX_ACTIVE(tx_act[0]), .i_TX_DONE(done_m[0]),
    .o_BUSY(busy[0]), .o_FRAME_DONE(fdone[0]), .o_State(st[0])
  );

  uart_tx_data #(.GAP_CYCLES(4), .COORD_W(16)) u_dut_g4 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_SEND(send), .i_COLOR_FLAG(flag),
    .i_THRESHOLD(thr), .i_X(x), .i_Y(y), .o_TX_DV(dv[1]),
    .o_TX_BYTE(tbyte[1]), .i_TX_ACTIVE(tx_act[1]), .i_TX_DONE(done_m[1]),
    .o_BUSY(busy[1]), .o_FRAME_DONE(fdone[1]), .o_State(st[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-UART model
  initial begin
    for (int k = 0; k < 2; k++) begin
      act_m[k] = 1'b0; done_m[k] = 1'b0; cnt_m[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      done_m[k] <= 1'b0;
      if (dv[k] && !act_m[k]) begin
        act_m[k] <= 1'b1;
        cnt_m[k] <= 10;
      end else if (act_m[k]) begin
        if (cnt_m[k] == 1) begin
          act_m[k]  <= 1'b0;
          done_m[k] <= 1'b1;
        end
        cnt_m[k] <= cnt_m[k] - 1;
      end
    end
  end

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rxb [2][16];
  int nrx [2];
  int nfd [2];
  int last_done_cyc [2];
  int first_dv_cyc [2];
  logic prev_dv [2];
  int pend [2];
  int send_cyc;

  initial begin
    for (int k = 0; k < 2; k++) begin
      nrx[k] = 0; nfd[k] = 0; last_done_cyc[k] = 0; first_dv_cyc[k] = 0;
      prev_dv[k] = 1'b0; pend[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dv[k]) begin
        check($sformatf("dv_width%0d", k), prev_dv[k], 1'b0);
        check($sformatf("busy_dv%0d", k), busy[k], 1'b1);
        check($sformatf("dv_wo_done%0d", k), pend[k], 0);
        if (nrx[k] == 0) first_dv_cyc[k] = cyc;
        else if (k == 1) check("gap_ge4", (cyc - last_done_cyc[k]) >= 5, 1'b1);
        if (nrx[k] < 16) rxb[k][nrx[k]] = tbyte[k];
        nrx[k]++;
        pend[k] = 1;
      end
      if (done_m[k]) begin
        last_done_cyc[k] = cyc;
        pend[k] = 0;
      end
      if (fdone[k]) begin
        nfd[k]++;
        check($sformatf("busy_end%0d", k), busy[k], 1'b0);
      end
      prev_dv[k] = dv[k];
    end
  end

  logic [7:0] basic_exp [12] = '{8'h53, 8'h54, 8'h01, 8'h64, 8'h01, 8'h23,
                                 8'h04, 8'h56, 8'h15, 8'h45, 8'h4E, 8'h44};
  logic [7:0] bound_exp [12] = '{8'h53, 8'h54, 8'h00, 8'hFF, 8'h00, 8'h00,
                                 8'hFF, 8'hFF, 8'hFF, 8'h45, 8'h4E, 8'h44};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      nrx[k] = 0;
      nfd[k] = 0;
    end
  endtask

  task automatic pulse_send();
    send = 1'b1;
    send_cyc = cyc;
    tick(1);
    send = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!(nfd[0] >= 1 && nfd[1] >= 1) && t < 3000) begin
      tick(1);
      t++;
    end
    if (t >= 3000) check({tag, "_timeout"}, 0, 1);
    tick(3);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int t;
    t = 0;
    while (nrx[0] < n && t < 1000) begin
      tick(1);
      t++;
    end
    if (t >= 1000) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [12]);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_n%0d", tag, k), nrx[k], 12);
      check($sformatf("%s_fd%0d", tag, k), nfd[k], 1);
      for (int i = 0; i < 12; i++)
        check($sformatf("%s_b%0d_%0d", tag, i, k), rxb[k][i], exp[i]);
      check($sformatf("%s_st%0d", tag, k), st[k], 3'd0);
    end
  endtask

  task automatic set_basic();
    flag = 1'b1; thr = 8'h64; x = 16'h0123; y = 16'h0456;
  endtask

  initial begin
    rst_n = 1'b0; send = 1'b0; hold_active = 1'b0;
    flag = 1'b0; thr = '0; x = '0; y = '0;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_dv%0d", k), dv[k], 1'b0);
      check($sformatf("rst_byte%0d", k), tbyte[k], 8'h00);
      check($sformatf("rst_busy%0d", k), busy[k], 1'b0);
      check($sformatf("rst_fd%0d", k), fdone[k], 1'b0);
      check($sformatf("rst_st%0d", k), st[k], 3'd0);
    end
    rst_n = 1'b1;
    tick(2);

    // Basic frame with latency and busy window
    set_basic();
    clear_mon();
    pulse_send();
    check("busy_start0", busy[0], 1'b1);
    check("busy_start1", busy[1], 1'b1);
    wait_done("basic");
    check("latency0", first_dv_cyc[0] - send_cyc, 2);
    check("latency1", first_dv_cyc[1] - send_cyc, 2);
    check_frame("basic", basic_exp);

    // Inputs change after the snapshot
    clear_mon();
    pulse_send();
    tick(1);
    x = 16'hFFFF; flag = 1'b0;
    wait_done("snap");
    check_frame("snap", basic_exp);

    // Second request during byte 5 must be dropped
    set_basic();
    clear_mon();
    pulse_send();
    wait_bytes("rej", 6);
    pulse_send();
    wait_done("rej");
    tick(60);
    check_frame("rej", basic_exp);

    // Transmitter held busy before byte 0
    clear_mon();
    hold_active = 1'b1;
    pulse_send();
    tick(30);
    check("hold_nodv0", nrx[0], 0);
    check("hold_nodv1", nrx[1], 0);
    check("hold_st0", st[0], 3'd2);
    check("hold_st1", st[1], 3'd2);
    hold_active = 1'b0;
    wait_done("hold");
    check_frame("hold", basic_exp);

    // Reset during byte 7
    clear_mon();
    pulse_send();
    wait_bytes("mrst", 8);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mrst_dv%0d", k), dv[k], 1'b0);
      check($sformatf("mrst_byte%0d", k), tbyte[k], 8'h00);
      check($sformatf("mrst_busy%0d", k), busy[k], 1'b0);
      check($sformatf("mrst_st%0d", k), st[k], 3'd0);
    end
    tick(3);
    rst_n = 1'b1;
    tick(30);
    check("mrst_nofd0", nfd[0], 0);
    check("mrst_nofd1", nfd[1], 0);
    clear_mon();
    pulse_send();
    wait_done("after_rst");
    check_frame("after_rst", basic_exp);

    // Flag 0 and extreme field values
    flag = 1'b0; thr = 8'hFF; x = 16'h0000; y = 16'hFFFF;
    clear_mon();
    pulse_send();
    wait_done("bound");
    check_frame("bound", bound_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
